md5_signature_collector: RTL and testbench



---
 rtl/md5_signature_collector.sv | 91 +++++++++
 tb/tb_md5_signature_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/md5_signature_collector.sv
// Folds the four MD5 output words into a 32-bit MISR over a programmable window
// after a warm-up delay, and publishes the final signature with a one-cycle strobe.
module md5_signature_collector #(
   parameter int unsigned WARMUP = 64,
   parameter int unsigned WINDOW = 256,
   parameter logic [31:0] POLY   = 32'h04C11DB7,
   parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a64,
   input  logic [31:0] b64,
   input  logic [31:0] c64,
   input  logic [31:0] d64,
   output logic [31:0] signature,
   output logic        sig_valid,
   output logic        busy
);

   localparam int unsigned MAX_CNT = (WARMUP > WINDOW) ? WARMUP : WINDOW;
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
   localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_ACCUM  = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_misr;
   logic [31:0]      w_fold;
   logic [31:0]      w_misr_next;

   assign w_fold      = a64 ^ b64 ^ c64 ^ d64;
   assign w_misr_next = {r_misr[30:0], 1'b0} ^ (r_misr[31] ? POLY : 32'h0) ^ w_fold;

   // Shared counter runs 0..LAST in each timed state; the terminal compare ends the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_misr    <= SEED;
         signature <= 32'h0;
         sig_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         sig_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_misr <= SEED;
                  r_cnt  <= '0;
                  busy   <= 1'b1;
                  if (WARMUP == 0) r_state <= S_ACCUM;
                  else             r_state <= S_WARMUP;
               end
            end
            S_WARMUP: begin
               if (r_cnt == WARM_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_ACCUM;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ACCUM: begin
               r_misr <= w_misr_next;
               if (r_cnt == WIN_LAST) begin
                  r_cnt     <= '0;
                  signature <= w_misr_next;
                  sig_valid <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md5_signature_collector.sv
// Directed bench for md5_signature_collector: single fold, feedback, warm-up gating,
// latency, back-to-back runs and mid-run reset.
module tb_md5_signature_collector;

   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
   logic [31:0] a = '0, b = '0, c = '0, d = '0;
   logic [31:0] sig0, sig1, sig2;
   logic        v0, v1, v2, busy0, busy1, busy2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   md5_signature_collector u0 (
      .clk(clk), .reset(reset), .start(st0),
      .a64(a), .b64(b), .c64(c), .d64(d),
      .signature(sig0), .sig_valid(v0), .busy(busy0)
   );

   md5_signature_collector #(.WARMUP(0), .WINDOW(1), .SEED(32'h0)) u1 (
      .clk(clk), .reset(reset), .start(st1),
      .a64(a), .b64(b), .c64(c), .d64(d),
      .signature(sig1), .sig_valid(v1), .busy(busy1)
   );

   md5_signature_collector #(.WARMUP(0), .WINDOW(1), .SEED(32'h80000000)) u2 (
      .clk(clk), .reset(reset), .start(st2),
      .a64(a), .b64(b), .c64(c), .d64(d),
      .signature(sig2), .sig_valid(v2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference MISR stepped n times with a constant fold value.
   function automatic logic [31:0] misr_model(input logic [31:0] seed, input int n,
                                              input logic [31:0] fold);
      logic [31:0] m;
      m = seed;
      for (int i = 0; i < n; i++)
         m = {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ fold;
      return m;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!v0 && n < 400);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int pulses;
      logic [31:0] exp_zero;
      logic [31:0] exp_rep;

      exp_zero = misr_model(32'hFFFFFFFF, 256, 32'h0);
      exp_rep  = misr_model(32'hFFFFFFFF, 256, 32'h12345678);

      // reset with toggling inputs and start
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = $urandom; b = $urandom; c = $urandom; d = $urandom;
         st0 = i[0]; st1 = i[0]; st2 = i[0];
         tick();
      end
      check("rst_sig", sig0, 32'h0);
      check("rst_valid", {31'h0, v0}, 32'h0);
      check("rst_busy", {31'h0, busy0}, 32'h0);
      check("rst_sig1", sig1, 32'h0);
      reset = 1'b0; st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(v0) + int'(v1) + int'(v2);
      end
      check("idle_no_valid", 32'(pulses), 32'h0);

      // single fold
      a = 32'h1; b = 32'h2; c = 32'h4; d = 32'h8; st1 = 1'b1;
      tick();
      st1 = 1'b0;
      check("fold_busy", {31'h0, busy1}, 32'h1);
      check("fold_early_valid", {31'h0, v1}, 32'h0);
      tick();
      check("fold_sig", sig1, 32'h0000000F);
      check("fold_valid", {31'h0, v1}, 32'h1);
      check("fold_busy_done", {31'h0, busy1}, 32'h0);
      a = '0; b = '0; c = '0; d = '0;
      tick();
      check("fold_valid_drop", {31'h0, v1}, 32'h0);
      check("fold_hold", sig1, 32'h0000000F);

      a = 32'hFFFF0000; b = 32'h0000FFFF; st1 = 1'b1;
      tick();
      st1 = 1'b0;
      tick();
      check("fold2_sig", sig1, 32'hFFFFFFFF);

      // feedback path
      a = '0; b = '0; st2 = 1'b1;
      tick();
      st2 = 1'b0;
      tick();
      check("fb_sig", sig2, 32'h04C11DB7);
      a = 32'h1; st2 = 1'b1;
      tick();
      st2 = 1'b0;
      tick();
      check("fb_fold_sig", sig2, 32'h04C11DB6);
      a = '0;
      tick();

      // warm-up gating, latency, ignored mid-run starts
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
      check("warm_busy", {31'h0, busy0}, 32'h1);
      a = 32'hDEADBEEF;
      for (int i = 1; i <= 64; i++) begin
         st0 = (i == 30);
         tick();
      end
      a = '0;
      for (int i = 65; i <= 320; i++) begin
         st0 = (i == 100);
         tick();
         if (i == 319) begin
            check("warm_busy_319", {31'h0, busy0}, 32'h1);
            check("warm_valid_319", {31'h0, v0}, 32'h0);
         end
      end
      check("warm_valid", {31'h0, v0}, 32'h1);
      check("warm_busy_end", {31'h0, busy0}, 32'h0);
      check("warm_sig", sig0, exp_zero);
      tick();
      check("warm_valid_drop", {31'h0, v0}, 32'h0);
      check("warm_hold", sig0, exp_zero);
      check("warm_idle", {31'h0, busy0}, 32'h0);

      // back-to-back with start held high and repeating stimulus
      a = 32'h12345678; st0 = 1'b1;
      tick();
      wait_valid(n);
      check("b2b_lat1", 32'(n), 32'd320);
      check("b2b_sig1", sig0, exp_rep);
      wait_valid(n);
      check("b2b_period", 32'(n), 32'd321);
      check("b2b_sig2", sig0, exp_rep);
      st0 = 1'b0;
      tick();
      check("b2b_stop", {31'h0, busy0}, 32'h0);
      a = '0;

      // reset in the middle of ACCUM
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
      for (int i = 1; i < 100; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_busy", {31'h0, busy0}, 32'h0);
      check("mid_sig", sig0, 32'h0);
      check("mid_valid", {31'h0, v0}, 32'h0);
      pulses = 0;
      for (int i = 0; i < 330; i++) begin
         tick();
         pulses += int'(v0);
      end
      check("mid_no_valid", 32'(pulses), 32'h0);
      check("mid_sig_kept", sig0, 32'h0);
      st0 = 1'b1;
      tick();
      st0 = 1'b0;
      wait_valid(n);
      check("rerun_lat", 32'(n), 32'd320);
      check("rerun_sig", sig0, exp_zero);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
